switch_stats_monitor: RTL and testbench

- Synthesizable per-port traffic statistics and integrity monitor for an N-port packet switch; moves the bench-side drop/pending bookkeeping into hardware.
- Taps each port's ingress handshake, FIFO-full status, target mask and egress valid.
- Keeps saturating accept/drop/deliver counters, a global in-flight count with underflow detection, and an atomic snapshot plus register-read path for software and bench inspection.

---
 rtl/switch_stats_monitor_pkg.sv | 32 +++
 rtl/switch_stats_monitor_if.sv | 46 ++++
 rtl/switch_stats_monitor_stat_counter.sv | 47 ++++
 rtl/switch_stats_monitor.sv | 194 +++++++++++++++++++
 tb/tb_switch_stats_monitor.sv | 191 +++++++++++++++++++
 5 files changed

// File: rtl/switch_stats_monitor_pkg.sv
// Shared types and helpers for the switch statistics monitor.
package switch_stats_pkg;

    // Register-read field selector.
    typedef enum logic [1:0] {
        ACC  = 2'd0,
        DROP = 2'd1,
        DLV  = 2'd2,
        INFL = 2'd3
    } stat_field_e;

    // Snapshot sequencing states.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        HOLD    = 2'd2
    } snap_state_e;

    // Widest target mask the popcount helper accepts.
    localparam int MASK_MAX_W = 32;

    // Number of set bits in a (zero-extended) target mask.
    function automatic int unsigned popcount_mask(input logic [MASK_MAX_W-1:0] mask);
        int unsigned n;
        n = 0;
        for (int b = 0; b < MASK_MAX_W; b++) begin
            n = n + 32'(mask[b]);
        end
        return n;
    endfunction

endpackage

// File: rtl/switch_stats_monitor_if.sv
// Tap and register-access bundle between the switch (or bench) and the monitor.
interface switch_stats_monitor_if
    import switch_stats_pkg::*;
#(
    parameter int NUM_PORTS = 4,
    parameter int CNT_W     = 32,
    parameter int INFL_W    = 16
) ();
    // One extra index bit so that out-of-range port numbers can be presented.
    localparam int PORT_W = $clog2(NUM_PORTS) + 1;

    logic [NUM_PORTS-1:0]           valid_in;
    logic [NUM_PORTS-1:0]           fifo_full;
    logic [NUM_PORTS*NUM_PORTS-1:0] target_in;
    logic [NUM_PORTS-1:0]           valid_out;
    logic                           clr;
    logic                           snap_req;
    logic                           snap_ack;
    logic                           snap_valid;
    logic                           rd_en;
    logic [PORT_W-1:0]              rd_port;
    stat_field_e                    rd_field;
    logic [CNT_W-1:0]               rd_data;
    logic                           rd_valid;
    logic [INFL_W-1:0]              in_flight;
    logic                           quiet;
    logic                           sat_flag;
    logic                           underflow_err;

    // Switch / software side.
    modport master (
        output valid_in, fifo_full, target_in, valid_out, clr,
               snap_req, snap_ack, rd_en, rd_port, rd_field,
        input  snap_valid, rd_data, rd_valid, in_flight, quiet,
               sat_flag, underflow_err
    );

    // Monitor side.
    modport slave (
        input  valid_in, fifo_full, target_in, valid_out, clr,
               snap_req, snap_ack, rd_en, rd_port, rd_field,
        output snap_valid, rd_data, rd_valid, in_flight, quiet,
               sat_flag, underflow_err
    );

endinterface

// File: rtl/switch_stats_monitor_stat_counter.sv
// Saturating statistics counter with synchronous clear and same-cycle increment.
module stat_counter #(
    parameter int CNT_W = 32,
    parameter int INC_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [INC_W-1:0] inc_i,
    input  logic             clr_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic [CNT_W-1:0] cnt_d_o,
    output logic             sat_o
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] base;
    logic [CNT_W-1:0] inc_ext;

    // Next value: clear restarts from zero but still takes this cycle's increment.
    always_comb begin
        // NOTE: every output of a combinational block is assigned on every path so no latch is inferred.
        base    = clr_i ? '0 : cnt_q;
        inc_ext = CNT_W'(inc_i);
        sat_o   = 1'b0;
        cnt_d   = base + inc_ext;
        if (base >= CNT_MAX - inc_ext) begin
            cnt_d = CNT_MAX;
            sat_o = 1'b1;
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o   = cnt_q;
    assign cnt_d_o = cnt_d;

endmodule

// File: rtl/switch_stats_monitor.sv
// Per-port accept/drop/deliver statistics, in-flight tracking, snapshot and read path.
module switch_stats_monitor
    import switch_stats_pkg::*;
#(
    parameter int NUM_PORTS = 4,
    parameter int CNT_W     = 32,
    parameter int INFL_W    = 16
) (
    input logic                  clk,
    input logic                  rst,
    switch_stats_monitor_if.slave bus
);
    localparam int W_W    = $clog2(NUM_PORTS + 1);
    localparam int SUM_W  = INFL_W + $clog2(NUM_PORTS) + 1;
    localparam int PORT_W = $clog2(NUM_PORTS) + 1;
    localparam int WIDE_W = (CNT_W > INFL_W) ? CNT_W : INFL_W;
    localparam logic signed [SUM_W-1:0] INFL_MAX_S = SUM_W'({INFL_W{1'b1}});

    logic [W_W-1:0]   weight   [NUM_PORTS];
    logic [W_W-1:0]   acc_inc  [NUM_PORTS];
    logic [W_W-1:0]   drop_inc [NUM_PORTS];
    logic [W_W-1:0]   dlv_inc  [NUM_PORTS];

    logic [CNT_W-1:0] acc_cnt  [NUM_PORTS];
    logic [CNT_W-1:0] drop_cnt [NUM_PORTS];
    logic [CNT_W-1:0] dlv_cnt  [NUM_PORTS];
    logic [CNT_W-1:0] acc_nxt  [NUM_PORTS];
    logic [CNT_W-1:0] drop_nxt [NUM_PORTS];
    logic [CNT_W-1:0] dlv_nxt  [NUM_PORTS];
    logic [3*NUM_PORTS-1:0] cnt_sat;

    logic [CNT_W-1:0] shd_acc_q  [NUM_PORTS];
    logic [CNT_W-1:0] shd_drop_q [NUM_PORTS];
    logic [CNT_W-1:0] shd_dlv_q  [NUM_PORTS];
    logic [INFL_W-1:0] shd_infl_q;
    snap_state_e       state_q;
    logic              snap_valid_q;

    logic signed [SUM_W-1:0] acc_total;
    logic signed [SUM_W-1:0] dlv_total;
    logic signed [SUM_W-1:0] infl_sum;
    logic [INFL_W-1:0] in_flight_q, in_flight_d;
    logic              infl_under, infl_sat;
    logic              sat_flag_q, sat_flag_d;
    logic              underflow_q, underflow_d;

    logic [WIDE_W-1:0] infl_wide;
    logic [CNT_W-1:0]  rd_data_q, rd_data_d;
    logic              rd_valid_q;

    // Per-port event weights from the target-mask popcount.
    always_comb begin
        for (int i = 0; i < NUM_PORTS; i++) begin
            weight[i]   = W_W'(popcount_mask(MASK_MAX_W'(bus.target_in[i*NUM_PORTS +: NUM_PORTS])));
            acc_inc[i]  = (bus.valid_in[i] && !bus.fifo_full[i]) ? weight[i] : '0;
            drop_inc[i] = (bus.valid_in[i] &&  bus.fifo_full[i]) ? weight[i] : '0;
            dlv_inc[i]  = W_W'(bus.valid_out[i]);
        end
    end

    for (genvar g = 0; g < NUM_PORTS; g++) begin : g_port
        stat_counter #(.CNT_W(CNT_W), .INC_W(W_W)) u_acc (
            .clk(clk), .rst(rst), .inc_i(acc_inc[g]), .clr_i(bus.clr),
            .cnt_o(acc_cnt[g]), .cnt_d_o(acc_nxt[g]), .sat_o(cnt_sat[3*g])
        );
        stat_counter #(.CNT_W(CNT_W), .INC_W(W_W)) u_drop (
            .clk(clk), .rst(rst), .inc_i(drop_inc[g]), .clr_i(bus.clr),
            .cnt_o(drop_cnt[g]), .cnt_d_o(drop_nxt[g]), .sat_o(cnt_sat[3*g+1])
        );
        stat_counter #(.CNT_W(CNT_W), .INC_W(W_W)) u_dlv (
            .clk(clk), .rst(rst), .inc_i(dlv_inc[g]), .clr_i(bus.clr),
            .cnt_o(dlv_cnt[g]), .cnt_d_o(dlv_nxt[g]), .sat_o(cnt_sat[3*g+2])
        );
    end

    // In-flight update in a widened signed domain, clamped at both ends; sticky flags.
    always_comb begin
        acc_total = '0;
        dlv_total = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            acc_total = acc_total + $signed(SUM_W'(acc_inc[i]));
            dlv_total = dlv_total + $signed(SUM_W'(dlv_inc[i]));
        end
        infl_sum    = $signed(SUM_W'(in_flight_q)) + acc_total - dlv_total;
        infl_under  = 1'b0;
        infl_sat    = 1'b0;
        in_flight_d = infl_sum[INFL_W-1:0];
        if (infl_sum[SUM_W-1]) begin
            in_flight_d = '0;
            infl_under  = 1'b1;
        end else if (infl_sum > INFL_MAX_S) begin
            in_flight_d = '1;
            infl_sat    = 1'b1;
        end
        sat_flag_d  = (bus.clr ? 1'b0 : sat_flag_q) | (|cnt_sat) | infl_sat;
        underflow_d = (bus.clr ? 1'b0 : underflow_q) | infl_under;
    end

    // Live in-flight count and sticky flags; clr deliberately leaves in_flight alone.
    always_ff @(posedge clk) begin
        if (rst) begin
            in_flight_q <= '0;
            sat_flag_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            in_flight_q <= in_flight_d;
            sat_flag_q  <= sat_flag_d;
            underflow_q <= underflow_d;
        end
    end

    // Snapshot FSM: CAPTURE latches the values this edge writes into the live counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            snap_valid_q <= 1'b0;
            shd_infl_q   <= '0;
            // NOTE: the shadows are a handful of registers, not a RAM, so resetting them is cheap and keeps reads deterministic.
            for (int i = 0; i < NUM_PORTS; i++) begin
                shd_acc_q[i]  <= '0;
                shd_drop_q[i] <= '0;
                shd_dlv_q[i]  <= '0;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.snap_req) state_q <= CAPTURE;
                end
                CAPTURE: begin
                    for (int i = 0; i < NUM_PORTS; i++) begin
                        shd_acc_q[i]  <= acc_nxt[i];
                        shd_drop_q[i] <= drop_nxt[i];
                        shd_dlv_q[i]  <= dlv_nxt[i];
                    end
                    shd_infl_q   <= in_flight_d;
                    state_q      <= HOLD;
                    snap_valid_q <= 1'b1;
                end
                HOLD: begin
                    if (bus.snap_ack) begin
                        state_q      <= IDLE;
                        snap_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q      <= IDLE;
                    snap_valid_q <= 1'b0;
                end
            endcase
        end
    end

    // Read mux: shadows while a snapshot is held, live values otherwise.
    always_comb begin
        rd_data_d = '0;
        infl_wide = WIDE_W'(snap_valid_q ? shd_infl_q : in_flight_q);
        case (bus.rd_field)
            ACC, DROP, DLV: begin
                for (int p = 0; p < NUM_PORTS; p++) begin
                    if (bus.rd_port == PORT_W'(p)) begin
                        if (bus.rd_field == ACC)
                            rd_data_d = snap_valid_q ? shd_acc_q[p] : acc_cnt[p];
                        else if (bus.rd_field == DROP)
                            rd_data_d = snap_valid_q ? shd_drop_q[p] : drop_cnt[p];
                        else
                            rd_data_d = snap_valid_q ? shd_dlv_q[p] : dlv_cnt[p];
                    end
                end
            end
            INFL:    rd_data_d = infl_wide[CNT_W-1:0];
            default: rd_data_d = '0;
        endcase
    end

    // Registered read response, one result per rd_en cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= bus.rd_en;
            if (bus.rd_en) rd_data_q <= rd_data_d;
        end
    end

    assign bus.snap_valid    = snap_valid_q;
    assign bus.rd_data       = rd_data_q;
    assign bus.rd_valid      = rd_valid_q;
    assign bus.in_flight     = in_flight_q;
    assign bus.quiet         = (in_flight_q == '0);
    assign bus.sat_flag      = sat_flag_q;
    assign bus.underflow_err = underflow_q;

endmodule

// File: tb/tb_switch_stats_monitor.sv
// Directed bench for switch_stats_monitor with a 4-bit counter width to reach saturation quickly.
module tb_switch_stats_monitor;
    import switch_stats_pkg::*;

    localparam int NP = 4;
    localparam int CW = 4;
    localparam int IW = 16;

    logic clk = 1'b0;
    logic rst;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    switch_stats_monitor_if #(.NUM_PORTS(NP), .CNT_W(CW), .INFL_W(IW)) bus ();

    switch_stats_monitor #(.NUM_PORTS(NP), .CNT_W(CW), .INFL_W(IW)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance one edge and settle just past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present an ingress event on one port for n cycles.
    task automatic ingress(input int port, input logic [NP-1:0] mask, input logic full, input int n);
        bus.valid_in[port]            = 1'b1;
        bus.fifo_full[port]           = full;
        bus.target_in[port*NP +: NP]  = mask;
        for (int k = 0; k < n; k++) tick();
        bus.valid_in[port]            = 1'b0;
        bus.fifo_full[port]           = 1'b0;
        bus.target_in[port*NP +: NP]  = '0;
    endtask

    task automatic deliver(input int port, input int n);
        bus.valid_out[port] = 1'b1;
        for (int k = 0; k < n; k++) tick();
        bus.valid_out[port] = 1'b0;
    endtask

    task automatic read(input logic [2:0] port, input stat_field_e f, input logic [31:0] exp, input string tag);
        bus.rd_en    = 1'b1;
        bus.rd_port  = port;
        bus.rd_field = f;
        tick();
        bus.rd_en    = 1'b0;
        check({tag, " rd_valid"}, 32'(bus.rd_valid), 32'd1);
        check(tag, 32'(bus.rd_data), exp);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst           = 1'b1;
        bus.valid_in  = '0;
        bus.fifo_full = '0;
        bus.target_in = '0;
        bus.valid_out = '0;
        bus.clr       = 1'b0;
        bus.snap_req  = 1'b0;
        bus.snap_ack  = 1'b0;
        bus.rd_en     = 1'b0;
        bus.rd_port   = '0;
        bus.rd_field  = ACC;
        tick();
        tick();
        rst = 1'b0;

        // Reset state.
        check("rst in_flight", 32'(bus.in_flight), 0);
        check("rst quiet", 32'(bus.quiet), 1);
        check("rst snap_valid", 32'(bus.snap_valid), 0);
        check("rst rd_valid", 32'(bus.rd_valid), 0);
        check("rst rd_data", 32'(bus.rd_data), 0);
        check("rst sat_flag", 32'(bus.sat_flag), 0);
        check("rst underflow", 32'(bus.underflow_err), 0);

        // Port 0, mask 1011 (weight 3), three accepted cycles.
        ingress(0, 4'b1011, 1'b0, 3);
        check("t1 in_flight", 32'(bus.in_flight), 9);
        check("t1 quiet", 32'(bus.quiet), 0);
        read(3'd0, ACC, 9, "t1 acc0");
        read(3'd0, DROP, 0, "t1 drop0");
        read(3'd0, INFL, 9, "t1 infl");

        // Port 2, mask 0110 (weight 2), FIFO full for two cycles.
        ingress(2, 4'b0110, 1'b1, 2);
        read(3'd2, DROP, 4, "t2 drop2");
        read(3'd2, ACC, 0, "t2 acc2");
        check("t2 in_flight", 32'(bus.in_flight), 9);

        // Zero mask counts nothing.
        ingress(3, 4'b0000, 1'b0, 1);
        read(3'd3, ACC, 0, "t2 zero-mask acc3");
        check("t2 zero-mask in_flight", 32'(bus.in_flight), 9);

        // Drain with nine deliveries on port 1, then one too many on port 3.
        deliver(1, 9);
        check("t3 in_flight", 32'(bus.in_flight), 0);
        check("t3 quiet", 32'(bus.quiet), 1);
        check("t3 underflow before", 32'(bus.underflow_err), 0);
        read(3'd1, DLV, 9, "t3 dlv1");
        deliver(3, 1);
        check("t3 underflow", 32'(bus.underflow_err), 1);
        check("t3 in_flight clamp", 32'(bus.in_flight), 0);
        read(3'd3, DLV, 1, "t3 dlv3");

        // Port 1 to 14 (4+4+4+2), then weight 3 saturates at 15.
        ingress(1, 4'b1111, 1'b0, 3);
        ingress(1, 4'b0011, 1'b0, 1);
        read(3'd1, ACC, 14, "t4 acc1 preload");
        check("t4 sat before", 32'(bus.sat_flag), 0);
        ingress(1, 4'b0111, 1'b0, 1);
        check("t4 sat_flag", 32'(bus.sat_flag), 1);
        read(3'd1, ACC, 15, "t4 acc1 saturated");
        check("t4 in_flight", 32'(bus.in_flight), 17);

        // Clear with a weight-2 accept in the same cycle.
        bus.clr = 1'b1;
        ingress(1, 4'b0011, 1'b0, 1);
        bus.clr = 1'b0;
        check("t4 clr sat_flag", 32'(bus.sat_flag), 0);
        check("t4 clr underflow", 32'(bus.underflow_err), 0);
        check("t4 clr keeps in_flight", 32'(bus.in_flight), 19);
        read(3'd1, ACC, 2, "t4 clr acc1");
        read(3'd0, ACC, 0, "t4 clr acc0");
        read(3'd1, DLV, 0, "t4 clr dlv1");

        // Snapshot: 4 accepts, request, 5th accept lands in the CAPTURE cycle.
        ingress(0, 4'b0001, 1'b0, 4);
        bus.snap_req = 1'b1;
        tick();
        bus.snap_req = 1'b0;
        check("t5 capture snap_valid", 32'(bus.snap_valid), 0);
        ingress(0, 4'b0001, 1'b0, 1);
        check("t5 hold snap_valid", 32'(bus.snap_valid), 1);
        ingress(0, 4'b0001, 1'b0, 1);
        bus.snap_req = 1'b1;
        ingress(0, 4'b0001, 1'b0, 1);
        bus.snap_req = 1'b0;
        check("t5 in_flight", 32'(bus.in_flight), 26);
        read(3'd0, ACC, 5, "t5 shadow acc0");
        read(3'd1, ACC, 2, "t5 shadow acc1");
        bus.snap_ack = 1'b1;
        tick();
        bus.snap_ack = 1'b0;
        check("t5 ack snap_valid", 32'(bus.snap_valid), 0);
        read(3'd0, ACC, 7, "t5 live acc0");

        // Reset while holding a snapshot.
        bus.snap_req = 1'b1;
        tick();
        bus.snap_req = 1'b0;
        tick();
        check("t6 hold snap_valid", 32'(bus.snap_valid), 1);
        rst = 1'b1;
        tick();
        check("t6 rst snap_valid", 32'(bus.snap_valid), 0);
        check("t6 rst in_flight", 32'(bus.in_flight), 0);
        check("t6 rst quiet", 32'(bus.quiet), 1);
        rst = 1'b0;
        tick();
        check("t6 idle snap_valid", 32'(bus.snap_valid), 0);
        read(3'd5, ACC, 0, "t6 port5");
        read(3'd0, ACC, 0, "t6 acc0");
        read(3'd3, DLV, 0, "t6 dlv3");
        read(3'd0, INFL, 0, "t6 infl");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
